// File: rtl/kbd_pkg.sv
// Shared constants for the keypad matrix scanner: row meanings and scan FSM states.
package kbd_pkg;

    localparam int ROW_DEC_BIG   = 0;
    localparam int ROW_DEC_SMALL = 1;
    localparam int ROW_INC_SMALL = 2;
    localparam int ROW_INC_BIG   = 3;
    localparam int N_ROWS        = 4;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DWELL = 1'b1
    } scan_state_e;

endpackage

// File: rtl/kbd_key_deb.sv
// One key: debounce on per-frame samples, plus hold-to-repeat step generation.
// step_o is combinational and valid only in the sample cycle; accepted state is registered.
module kbd_key_deb
    import kbd_pkg::*;
#(
    parameter int DEB_N     = 2,
    parameter int REP_DELAY = 20,
    parameter int REP_RATE  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en_i,
    input  logic sample_i,
    input  logic clr_hold_i,
    output logic key_o,
    output logic step_o
);

    localparam int DW = $clog2(DEB_N + 1);
    localparam int HW = $clog2(REP_DELAY + 1);

    logic          acc_q,  acc_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hold_q, hold_d;

    always_comb begin
        acc_d  = acc_q;
        dcnt_d = dcnt_q;
        hold_d = hold_q;
        step_o = 1'b0;
        if (sample_en_i) begin
            if (sample_i != acc_q) begin
                if (dcnt_q == DW'(DEB_N - 1)) begin
                    acc_d  = sample_i;
                    dcnt_d = '0;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end else begin
                dcnt_d = '0;
            end

            // After the first repeat the counter rewinds by REP_RATE so the
            // same compare produces every later repeat.
            if (acc_d && !acc_q) begin
                step_o = 1'b1;
                hold_d = '0;
            end else if (acc_d) begin
                if (hold_q == HW'(REP_DELAY - 1)) begin
                    step_o = 1'b1;
                    hold_d = HW'(REP_DELAY - REP_RATE);
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end else begin
                hold_d = '0;
            end
        end
        if (clr_hold_i) begin
            hold_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= 1'b0;
            dcnt_q <= '0;
            hold_q <= '0;
        end else begin
            acc_q  <= acc_d;
            dcnt_q <= dcnt_d;
            hold_q <= hold_d;
        end
    end

    assign key_o = acc_q;

endmodule

// File: rtl/kbd_matrix_scan.sv
// Scans N_COLS keypad columns (blank gap between columns) and steps one channel value per column.
// data/frame_done update the cycle after the last column is sampled; no backpressure, host load wins.
module kbd_matrix_scan
    import kbd_pkg::*;
#(
    parameter int N_COLS     = 3,
    parameter int VAL_W      = 8,
    parameter int DWELL_CYC  = 416_666,
    parameter int BLANK_CYC  = 250,
    parameter int STEP_SMALL = 1,
    parameter int STEP_BIG   = 4,
    parameter int DEB_N      = 2,
    parameter int REP_DELAY  = 20,
    parameter int REP_RATE   = 4,
    parameter int SATURATE   = 1,
    localparam int CH_W      = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_ROWS-1:0]         col_data,
    output logic [N_COLS-1:0]         col_power,
    input  logic                      ld_en,
    input  logic [CH_W-1:0]           ld_ch,
    input  logic [VAL_W-1:0]          ld_val,
    output logic [N_COLS*VAL_W-1:0]   data,
    output logic [N_COLS*N_ROWS-1:0]  keys,
    output logic                      frame_done
);

    localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int XW      = VAL_W + 1;

    logic [N_ROWS-1:0]       sync1_q, sync2_q;
    scan_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CH_W-1:0]         col_q, col_d;
    logic [VAL_W-1:0]        wval_q [N_COLS];
    logic [VAL_W-1:0]        wval_d [N_COLS];
    logic [N_COLS*VAL_W-1:0] data_q, data_d;
    logic                    frame_done_q;
    logic                    sample_w, publish_w;
    logic [N_COLS-1:0][N_ROWS-1:0] step_w;

    // Highest row index wins when several rows step in the same sample.
    function automatic logic [VAL_W-1:0] apply_step(input logic [VAL_W-1:0] v,
                                                    input logic [N_ROWS-1:0] stp);
        logic [XW-1:0] ext;
        logic [XW-1:0] res;
        ext = {1'b0, v};
        res = ext;
        if (stp[ROW_INC_BIG] || stp[ROW_INC_SMALL]) begin
            res = ext + (stp[ROW_INC_BIG] ? XW'(STEP_BIG) : XW'(STEP_SMALL));
            if (SATURATE != 0 && res[VAL_W]) begin
                res = {1'b0, {VAL_W{1'b1}}};
            end
        end else if (stp[ROW_DEC_SMALL] || stp[ROW_DEC_BIG]) begin
            res = ext - (stp[ROW_DEC_SMALL] ? XW'(STEP_SMALL) : XW'(STEP_BIG));
            if (SATURATE != 0 && res[VAL_W]) begin
                res = '0;
            end
        end
        return res[VAL_W-1:0];
    endfunction

    assign sample_w  = (state_q == ST_DWELL) && (cnt_q == CNT_W'(1));
    assign publish_w = sample_w && (col_q == CH_W'(N_COLS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DWELL;
                    cnt_d   = CNT_W'(DWELL_CYC);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DWELL: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = CNT_W'(BLANK_CYC);
                    col_d   = (col_q == CH_W'(N_COLS - 1)) ? '0 : col_q + CH_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = CNT_W'(BLANK_CYC);
            end
        endcase
    end

    always_comb begin
        for (int c = 0; c < N_COLS; c++) begin
            col_power[c] = (state_q == ST_DWELL) && (col_q == CH_W'(c));
        end
    end

    for (genvar c = 0; c < N_COLS; c++) begin : g_col
        for (genvar r = 0; r < N_ROWS; r++) begin : g_row
            kbd_key_deb #(
                .DEB_N    (DEB_N),
                .REP_DELAY(REP_DELAY),
                .REP_RATE (REP_RATE)
            ) u_deb (
                .clk        (clk),
                .rst_n      (rst_n),
                .sample_en_i(sample_w && (col_q == CH_W'(c))),
                .sample_i   (sync2_q[r]),
                .clr_hold_i (ld_en && (ld_ch == CH_W'(c))),
                .key_o      (keys[c*N_ROWS + r]),
                .step_o     (step_w[c][r])
            );
        end
    end

    // step_w is all-zero outside a column's sample cycle, so no extra gating is needed.
    always_comb begin
        for (int c = 0; c < N_COLS; c++) begin
            wval_d[c] = apply_step(wval_q[c], step_w[c]);
            if (ld_en && (ld_ch == CH_W'(c))) begin
                wval_d[c] = ld_val;
            end
        end
    end

    always_comb begin
        data_d = data_q;
        if (publish_w) begin
            for (int c = 0; c < N_COLS; c++) begin
                data_d[c*VAL_W +: VAL_W] = wval_d[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            state_q      <= ST_BLANK;
            cnt_q        <= CNT_W'(BLANK_CYC);
            col_q        <= '0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
            for (int c = 0; c < N_COLS; c++) begin
                wval_q[c] <= '0;
            end
        end else begin
            sync1_q      <= col_data;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            col_q        <= col_d;
            data_q       <= data_d;
            frame_done_q <= publish_w;
            for (int c = 0; c < N_COLS; c++) begin
                wval_q[c] <= wval_d[c];
            end
        end
    end

    assign data       = data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_kbd_matrix_scan.sv
// Randomised scoreboard bench: saturating and wrapping scanners share one emulated keypad.
module tb_kbd_matrix_scan;

    localparam int NC    = 3;
    localparam int VW    = 8;
    localparam int DWELL = 20;
    localparam int BLANK = 5;
    localparam int SS    = 1;
    localparam int SB    = 4;
    localparam int DEBN  = 2;
    localparam int RDLY  = 20;
    localparam int RRATE = 4;
    localparam int FRAME = NC * (DWELL + BLANK);
    localparam int MAXV  = (1 << VW) - 1;

    typedef struct packed {
        logic [NC*VW-1:0] ds;
        logic [NC*VW-1:0] dw;
        logic [NC*4-1:0]  k;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       col_data;
    logic             ld_en = 1'b0;
    logic [1:0]       ld_ch = '0;
    logic [VW-1:0]    ld_val = '0;
    logic [NC-1:0]    cp_s, cp_w;
    logic [NC*VW-1:0] data_s, data_w;
    logic [NC*4-1:0]  keys_s, keys_w;
    logic             fd_s, fd_w;

    logic [3:0] press [NC];
    int   checks = 0;
    int   failures = 0;
    int   k = 0;
    exp_t exp_q [$];
    exp_t mon_e;

    int acc [NC][4];
    int dcnt [NC][4];
    int hold [NC][4];
    int vs [NC];
    int vw [NC];
    int delta_tab [4] = '{-SB, -SS, SS, SB};

    kbd_matrix_scan #(.N_COLS(NC), .VAL_W(VW), .DWELL_CYC(DWELL), .BLANK_CYC(BLANK),
        .STEP_SMALL(SS), .STEP_BIG(SB), .DEB_N(DEBN), .REP_DELAY(RDLY), .REP_RATE(RRATE),
        .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .col_data(col_data), .col_power(cp_s), .ld_en(ld_en),
        .ld_ch(ld_ch), .ld_val(ld_val), .data(data_s), .keys(keys_s), .frame_done(fd_s));

    kbd_matrix_scan #(.N_COLS(NC), .VAL_W(VW), .DWELL_CYC(DWELL), .BLANK_CYC(BLANK),
        .STEP_SMALL(SS), .STEP_BIG(SB), .DEB_N(DEBN), .REP_DELAY(RDLY), .REP_RATE(RRATE),
        .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .col_data(col_data), .col_power(cp_w), .ld_en(ld_en),
        .ld_ch(ld_ch), .ld_val(ld_val), .data(data_w), .keys(keys_w), .frame_done(fd_w));

    always #5 clk = ~clk;

    // Keypad: pressed keys of the powered column appear on the row lines.
    always_comb begin
        col_data = '0;
        for (int c = 0; c < NC; c++) begin
            if (cp_s[c]) col_data = col_data | press[c];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            vs[c] = 0;
            vw[c] = 0;
            for (int r = 0; r < 4; r++) begin
                acc[c][r] = 0; dcnt[c][r] = 0; hold[c][r] = 0;
            end
        end
    endtask

    task automatic model_load(input int ch, input int val);
        if (ch < NC) begin
            vs[ch] = val;
            vw[ch] = val;
            for (int r = 0; r < 4; r++) hold[ch][r] = 0;
        end
    endtask

    // One frame of key behaviour, then the expected published picture.
    task automatic model_frame();
        exp_t e;
        for (int c = 0; c < NC; c++) begin
            int best;
            best = -1;
            for (int r = 0; r < 4; r++) begin
                int prev, s, h;
                bit st;
                prev = acc[c][r];
                s = press[c][r] ? 1 : 0;
                st = 1'b0;
                if (s != prev) begin
                    dcnt[c][r]++;
                    if (dcnt[c][r] == DEBN) begin
                        acc[c][r] = s;
                        dcnt[c][r] = 0;
                    end
                end else begin
                    dcnt[c][r] = 0;
                end
                if (acc[c][r] == 1 && prev == 0) begin
                    hold[c][r] = 0;
                    st = 1'b1;
                end else if (acc[c][r] == 1) begin
                    hold[c][r]++;
                    h = hold[c][r];
                    st = (h == RDLY) || (h > RDLY && ((h - RDLY) % RRATE) == 0);
                end else begin
                    hold[c][r] = 0;
                end
                if (st) best = r;
            end
            if (best >= 0) begin
                int n;
                n = vs[c] + delta_tab[best];
                vs[c] = (n < 0) ? 0 : ((n > MAXV) ? MAXV : n);
                vw[c] = (vw[c] + delta_tab[best] + MAXV + 1) % (MAXV + 1);
            end
        end
        for (int c = 0; c < NC; c++) begin
            e.ds[c*VW +: VW] = VW'(vs[c]);
            e.dw[c*VW +: VW] = VW'(vw[c]);
            for (int r = 0; r < 4; r++) e.k[c*4 + r] = (acc[c][r] != 0);
        end
        exp_q.push_back(e);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fd_s && n < FRAME + 10);
        check("frame_done_seen", fd_s, 1);
    endtask

    task automatic run_frame(input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2);
        press[0] = p0;
        press[1] = p1;
        press[2] = p2;
        model_frame();
        wait_frame();
    endtask

    task automatic do_load(input int ch, input int val);
        ld_ch  = 2'(ch);
        ld_val = VW'(val);
        ld_en  = 1'b1;
        @(negedge clk);
        ld_en  = 1'b0;
        model_load(ch, val);
    endtask

    task automatic random_frames(input int n);
        for (int f = 0; f < n; f++) begin
            if ($urandom_range(0, 7) == 0) do_load(int'($urandom_range(0, 3)), int'($urandom_range(0, MAXV)));
            for (int c = 0; c < NC; c++)
                for (int r = 0; r < 4; r++)
                    if ($urandom_range(0, 5) == 0) press[c][r] = ~press[c][r];
            model_frame();
            wait_frame();
        end
    endtask

    // Scoreboard monitor: pops one expectation per published frame.
    always @(negedge clk) begin
        if (rst_n && (fd_s || fd_w)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL frame_done_without_expectation t=%0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("data_sat", data_s, mon_e.ds);
                check("data_wrap", data_w, mon_e.dw);
                check("keys_sat", keys_s, mon_e.k);
                check("keys_wrap", keys_w, mon_e.k);
            end
        end
    end

    // Scan timing: position within the frame gives the expected column drive.
    int          tp, tc, tq;
    logic [NC-1:0] pw_exp;
    always @(negedge clk) begin
        if (rst_n) begin
            tp = k % FRAME;
            tc = tp / (DWELL + BLANK);
            tq = tp % (DWELL + BLANK);
            pw_exp = (tq >= BLANK) ? NC'(1 << tc) : '0;
            check("col_power_sat", cp_s, pw_exp);
            check("col_power_wrap", cp_w, pw_exp);
            check("frame_done_timing", fd_s, (tp == 0 && k > 0));
            check("frame_done_wrap_timing", fd_w, (tp == 0 && k > 0));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < NC; c++) press[c] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_col_power", cp_s, 0);
        check("reset_data_sat", data_s, 0);
        check("reset_data_wrap", data_w, 0);
        check("reset_keys", keys_s, 0);
        check("reset_frame_done", fd_s, 0);
        rst_n = 1'b1;

        repeat (3) run_frame(4'b0000, 4'b0000, 4'b0000);
        repeat (3) run_frame(4'b0000, 4'b0100, 4'b0000);
        repeat (2) run_frame(4'b0000, 4'b0000, 4'b0000);
        repeat (RDLY + 2 * RRATE) run_frame(4'b1000, 4'b0000, 4'b0000);
        repeat (2) run_frame(4'b0000, 4'b0000, 4'b0000);
        do_load(0, 253);
        repeat (2) run_frame(4'b1000, 4'b0000, 4'b0000);
        repeat (2) run_frame(4'b0000, 4'b0000, 4'b0000);
        do_load(2, 1);
        repeat (2) run_frame(4'b0000, 4'b0000, 4'b0001);
        repeat (2) run_frame(4'b0000, 4'b0000, 4'b0000);
        repeat (3) run_frame(4'b1001, 4'b0000, 4'b0000);
        repeat (2) run_frame(4'b0000, 4'b0000, 4'b0000);
        run_frame(4'b0000, 4'b0010, 4'b0000);
        repeat (2) run_frame(4'b0000, 4'b0000, 4'b0000);
        do_load(3, 77);
        run_frame(4'b0000, 4'b0000, 4'b0000);

        random_frames(120);

        // Reset in the middle of column 1's dwell.
        begin
            int n;
            n = 0;
            while ((k % FRAME) != 40 && n < FRAME + 10) begin
                @(negedge clk);
                n++;
            end
        end
        check("col_power_before_reset", cp_s, 3'b010);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_col_power", cp_s, 0);
        check("midreset_data_sat", data_s, 0);
        check("midreset_data_wrap", data_w, 0);
        check("midreset_keys", keys_s, 0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        random_frames(40);

        repeat (3) @(negedge clk);
        check("expectations_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
